// File: rtl/divisor_sequencer.sv
// Steps a programmable clock divider through a table of divisors, holding each for a
// number of divided-clock toggles. Define SEQ_LOOP_EN to build the wrap-to-entry-0 option.
module divisor_sequencer #(
  parameter int DEPTH   = 8,
  parameter int DW      = 16,
  parameter int DWELL_W = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  input  logic [AW-1:0]      last_idx,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  input  logic               div_clk,
  output logic [DW-1:0]      div_value,
  output logic               div_load,
  output logic [AW-1:0]      step_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic {S_IDLE, S_DWELL} state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        tbl [DEPTH];
  logic                 div_clk_q;
  logic                 toggle;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [AW-1:0]        last_q, last_d;
  logic                 loop_q, loop_d;
  logic [DW-1:0]        value_d;
  logic                 load_d;
  logic [AW-1:0]        idx_d;
  logic                 done_d;

  assign toggle = div_clk ^ div_clk_q;
  assign busy   = (state_q == S_DWELL);

  // NOTE: the table is small and must read as zero after reset, so every entry
  // gets an explicit reset value; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (wr_en) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values; a table read at the same edge as a write sees old data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_clk_q <= 1'b0;
      cnt_q     <= '0;
      dwell_q   <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      div_value <= '0;
      div_load  <= 1'b0;
      step_idx  <= '0;
      done      <= 1'b0;
    end else begin
      div_clk_q <= div_clk;
      cnt_q     <= cnt_d;
      dwell_q   <= dwell_d;
      last_q    <= last_d;
      loop_q    <= loop_d;
      div_value <= value_d;
      div_load  <= load_d;
      step_idx  <= idx_d;
      done      <= done_d;
    end
  end

`ifndef SEQ_LOOP_EN
  logic loop_unused;
  assign loop_unused = loop;
`endif

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    last_d  = last_q;
    loop_d  = loop_q;
    value_d = div_value;
    load_d  = 1'b0;
    idx_d   = step_idx;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_DWELL;
          dwell_d = (dwell == '0) ? DWELL_W'(1) : dwell;
          last_d  = last_idx;
`ifdef SEQ_LOOP_EN
          loop_d  = loop;
`else
          loop_d  = 1'b0;
`endif
          value_d = tbl[0];
          idx_d   = '0;
          load_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      S_DWELL: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (toggle) begin
          if (cnt_q == dwell_q - DWELL_W'(1)) begin
            cnt_d = '0;
            if (step_idx < last_q) begin
              idx_d   = step_idx + AW'(1);
              value_d = tbl[step_idx + AW'(1)];
              load_d  = 1'b1;
`ifdef SEQ_LOOP_EN
            end else if (loop_q) begin
              idx_d   = '0;
              value_d = tbl[0];
              load_d  = 1'b1;
`endif
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_divisor_sequencer.sv
// Self-checking bench for divisor_sequencer: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural sequence model.
module tb_divisor_sequencer;

  localparam int DEPTH   = 8;
  localparam int DW      = 16;
  localparam int DWELL_W = 8;
  localparam int AW      = 3;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b0;
  logic               wr_en = 1'b0;
  logic [AW-1:0]      wr_addr = '0;
  logic [DW-1:0]      wr_data = '0;
  logic [AW-1:0]      last_idx = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic               loop = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               div_clk = 1'b0;
  logic [DW-1:0]      div_value;
  logic               div_load;
  logic [AW-1:0]      step_idx;
  logic               busy;
  logic               done;

  divisor_sequencer #(.DEPTH(DEPTH), .DW(DW), .DWELL_W(DWELL_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_idx(last_idx), .dwell(dwell), .loop(loop), .start(start), .stop(stop),
    .div_clk(div_clk), .div_value(div_value), .div_load(div_load),
    .step_idx(step_idx), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Divided-clock source: hold (0), random (-1) or toggle every N cycles.
  int tog_period = 0;
  int tog_cnt = 0;
  always @(negedge CLK) begin
    #2;
    if (tog_period > 0) begin
      tog_cnt++;
      if (tog_cnt >= tog_period) begin
        tog_cnt = 0;
        div_clk = ~div_clk;
      end
    end else if (tog_period < 0) begin
      div_clk = div_clk ^ 1'($urandom_range(0, 1));
    end
  end

  // Behavioural model: counts toggles seen in the current step and advances when
  // the count reaches the effective dwell.
  logic [DW-1:0] m_tab [DEPTH];
  bit            m_busy, m_load, m_done, m_loop, m_tog;
  int            m_idx, m_dwell, m_last, m_seen;
  logic [DW-1:0] m_val;
  logic          m_prev;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      foreach (m_tab[i]) m_tab[i] = '0;
      m_busy = 0; m_load = 0; m_done = 0; m_loop = 0;
      m_idx = 0; m_dwell = 1; m_last = 0; m_seen = 0;
      m_val = '0; m_prev = 1'b0;
    end else begin
      m_tog  = (div_clk != m_prev);
      m_prev = div_clk;
      m_load = 0;
      m_done = 0;
      if (!m_busy) begin
        if (start && !stop) begin
          m_busy  = 1;
          m_dwell = (dwell == 0) ? 1 : int'(dwell);
          m_last  = int'(last_idx);
`ifdef SEQ_LOOP_EN
          m_loop  = loop;
`else
          m_loop  = 0;
`endif
          m_idx   = 0;
          m_val   = m_tab[0];
          m_load  = 1;
          m_seen  = 0;
        end
      end else if (stop) begin
        m_busy = 0;
      end else if (m_tog) begin
        m_seen++;
        if (m_seen >= m_dwell) begin
          m_seen = 0;
          if (m_idx < m_last) begin
            m_idx++;
            m_val  = m_tab[m_idx];
            m_load = 1;
          end else if (m_loop) begin
            m_idx  = 0;
            m_val  = m_tab[0];
            m_load = 1;
          end else begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
      if (wr_en) m_tab[wr_addr] = wr_data;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge CLK) begin
    if (RST_N) begin
      check("div_value", 32'(div_value), 32'(m_val));
      check("div_load",  32'(div_load),  32'(m_load));
      check("step_idx",  32'(step_idx),  32'(m_idx));
      check("busy",      32'(busy),      32'(m_busy));
      check("done",      32'(done),      32'(m_done));
    end
  end

  // Event monitor for the directed scenarios.
  logic [DW-1:0] load_vals[$];
  int            load_idx[$];
  int            done_cnt = 0;
  always @(negedge CLK) begin
    if (RST_N) begin
      if (div_load) begin
        load_vals.push_back(div_value);
        load_idx.push_back(int'(step_idx));
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    load_vals.delete();
    load_idx.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic write_table();
    logic [DW-1:0] vals [4];
    vals = '{16'd4, 16'd9, 16'd2, 16'd0};
    for (int i = 0; i < 4; i++) begin
      tick();
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = vals[i];
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_value"}, 32'(div_value), 32'd0);
    check({tag, "_load"},  32'(div_load),  32'd0);
    check({tag, "_idx"},   32'(step_idx),  32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] exp_sweep [4];
    logic [AW-1:0] held;
    exp_sweep = '{16'd4, 16'd9, 16'd2, 16'd0};

    repeat (3) tick();
    check_outputs_zero("reset");
    RST_N = 1'b1;

    // Table writes never reach the divider.
    write_table();
    repeat (2) tick();
    check("write_no_value", 32'(div_value), 32'd0);
    check("write_no_load", 32'(load_vals.size()), 32'd0);

    // One-shot sweep, dwell 2, toggle every 3 cycles.
    last_idx = 3'd3; dwell = 8'd2; loop = 1'b0; tog_period = 3;
    clear_mon();
    pulse_start();
    wait_idle(200, "sweep_timeout");
    check("sweep_loads", 32'(load_vals.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("sweep_val", (load_vals.size() > i) ? 32'(load_vals[i]) : 32'hFFFF_FFFF, 32'(exp_sweep[i]));
    check("sweep_done", 32'(done_cnt), 32'd1);

    // dwell 0 behaves as dwell 1.
    dwell = 8'd0;
    clear_mon();
    pulse_start();
    wait_idle(200, "dwell0_timeout");
    check("dwell0_loads", 32'(load_vals.size()), 32'd4);
    check("dwell0_last", (load_vals.size() == 4) ? 32'(load_vals[3]) : 32'hFFFF_FFFF, 32'd0);
    check("dwell0_done", 32'(done_cnt), 32'd1);

    // Asynchronous reset in the middle of a sequence.
    dwell = 8'd2;
    pulse_start();
    repeat (5) tick();
    check("pre_reset_busy", 32'(busy), 32'd1);
    #1 RST_N = 1'b0;
    #1 check_outputs_zero("midrst");
    tick();
    RST_N = 1'b1;
    write_table();

`ifdef SEQ_LOOP_EN
    last_idx = 3'd1; loop = 1'b1; dwell = 8'd1; tog_period = 2;
    clear_mon();
    pulse_start();
    repeat (30) tick();
    check("loop_enough", 32'(load_idx.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++)
      check("loop_idx", (load_idx.size() > i) ? 32'(load_idx[i]) : 32'hFFFF_FFFF, 32'(i % 2));
    check("loop_no_done", 32'(done_cnt), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
`else
    last_idx = 3'd1; loop = 1'b1; dwell = 8'd1; tog_period = 2;
    clear_mon();
    pulse_start();
    wait_idle(100, "noloop_timeout");
    check("noloop_loads", 32'(load_idx.size()), 32'd2);
    check("noloop_last", (load_idx.size() == 2) ? 32'(load_idx[1]) : 32'hFFFF_FFFF, 32'd1);
    check("noloop_done", 32'(done_cnt), 32'd1);
`endif

    // Stop on the same edge as a completing toggle.
    last_idx = 3'd7; loop = 1'b0; dwell = 8'd1; tog_period = 1;
    repeat (2) tick();
    pulse_start();
    repeat (2) tick();
    held = step_idx;
    check("stop_pre_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_idx_held", 32'(step_idx), 32'(held));
    check("stop_no_load", 32'(div_load), 32'd0);
    check("stop_no_done", 32'(done), 32'd0);

    // Write to entry 1 on the edge that loads entry 1.
    last_idx = 3'd1; loop = 1'b1; dwell = 8'd1; tog_period = 1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'd77;
    tick();
    wr_en = 1'b0;
    check("rbw_old_value", 32'(div_value), 32'd9);
    check("rbw_idx", 32'(step_idx), 32'd1);
`ifdef SEQ_LOOP_EN
    repeat (2) tick();
    check("rbw_wrap_value", 32'(div_value), 32'd77);
    stop = 1'b1;
    tick();
    stop = 1'b0;
`else
    wait_idle(20, "rbw_timeout");
    clear_mon();
    pulse_start();
    wait_idle(20, "rbw2_timeout");
    check("rbw_new_value", (load_vals.size() > 1) ? 32'(load_vals[1]) : 32'hFFFF_FFFF, 32'd77);
`endif

    // start while busy is ignored.
    last_idx = 3'd3; dwell = 8'd4; loop = 1'b0; tog_period = 3;
    clear_mon();
    pulse_start();
    repeat (4) tick();
    held = step_idx;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_idx", 32'(step_idx), 32'(held));
    check("restart_no_load", 32'(div_load), 32'd0);
    wait_idle(400, "restart_timeout");
    check("restart_loads", 32'(load_vals.size()), 32'd4);
    check("restart_done", 32'(done_cnt), 32'd1);

    // Randomized traffic against the model.
    tog_period = -1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (i % 500 == 0) begin
        case ($urandom_range(0, 3))
          0: tog_period = -1;
          1: tog_period = 1;
          2: tog_period = 2;
          default: tog_period = 3;
        endcase
      end
      if (i == 1500) begin
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
      end
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = AW'($urandom);
      wr_data  = DW'($urandom);
      last_idx = AW'($urandom);
      dwell    = DWELL_W'($urandom_range(0, 3));
      loop     = 1'($urandom_range(0, 1));
      start    = ($urandom_range(0, 7) == 0);
      stop     = ($urandom_range(0, 40) == 0);
    end
    wr_en = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
